// File: rtl/synth_div_defs.sv
// synth_div_defs: shared FSM encodings, default operand width and the
// per-voice slice macro used by the multiplier/divider wrappers.
`ifndef SYNTH_DIV_DEFS_SV
`define SYNTH_DIV_DEFS_SV
`define SDD_SLICE(bus, i, w) bus[(i)*(w) +: (w)]
package synth_div_defs;
  localparam int C_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} div_state_t;
endpackage
`endif

// File: rtl/array_divider.sv
// array_divider: combinational unsigned restoring array divider; b==0 gives q=all-ones, r=a.
module array_divider #(
  parameter int C_WIDTH = 8,
  parameter int USE_CLA = 1
) (
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  output logic [C_WIDTH-1:0] q,
  output logic [C_WIDTH-1:0] r
);
  localparam bit CLA = USE_CLA != 0;
  logic [C_WIDTH:0] t, d;
  always_comb begin
    q = '0;
    r = '0;
    t = '0;
    d = '0;
    for (int i = C_WIDTH - 1; i >= 0; i--) begin
      t = {r, a[i]};
      d = CLA ? t - {1'b0, b} : t + ~{1'b0, b} + 1'b1;
      q[i] = t >= {1'b0, b};
      r = q[i] ? d[C_WIDTH-1:0] : t[C_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    any = |req;
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/div_voice_scheduler.sv
// div_voice_scheduler: round-robin sharing of one array divider among synth voices.
// Optional DIV_ZERO_DETECT_EN: b==0 bypasses the divider (q=all-ones, r=dividend).
module div_voice_scheduler import synth_div_defs::*; #(
  parameter int C_WIDTH     = C_WIDTH_DEF,
  parameter int N_VOICES    = 4,
  parameter int DIV_LATENCY = 2
) (
  input  logic                          ctl_clk,
  input  logic                          reset,
  input  logic [N_VOICES-1:0]           req,
  input  logic [N_VOICES*C_WIDTH-1:0]   voice_a,
  input  logic [N_VOICES*C_WIDTH-1:0]   voice_b,
  output logic [C_WIDTH-1:0]            div_a,
  output logic [C_WIDTH-1:0]            div_b,
  input  logic [C_WIDTH-1:0]            div_q,
  input  logic [C_WIDTH-1:0]            div_r,
  output logic [N_VOICES*C_WIDTH-1:0]   q_out,
  output logic [N_VOICES*C_WIDTH-1:0]   r_out,
  output logic [N_VOICES-1:0]           done,
  output logic [N_VOICES-1:0]           overrun,
  output logic                          busy
);
  localparam int IW = $clog2(N_VOICES);
  localparam int CW = DIV_LATENCY > 1 ? $clog2(DIV_LATENCY) : 1;
  div_state_t state, state_n;
  logic [N_VOICES-1:0] pending, gnt, clr;
  logic [IW-1:0] ptr, idx, g;
  logic [CW-1:0] cnt;
  logic any, zero;
  logic [C_WIDTH-1:0] a_sel, b_sel;
  rr_arbiter #(.N(N_VOICES)) u_arb (.req(pending), .ptr(ptr), .gnt(gnt), .idx(idx), .any(any));
  assign a_sel = `SDD_SLICE(voice_a, idx, C_WIDTH);
  assign b_sel = `SDD_SLICE(voice_b, idx, C_WIDTH);
`ifdef DIV_ZERO_DETECT_EN
  assign zero = b_sel == '0;
`else
  assign zero = 1'b0;
`endif
  assign clr  = state == IDLE ? gnt : '0;
  assign done = state == DONE ? N_VOICES'(1) << g : '0;
  assign busy = state != IDLE || |pending;
  always_comb
    state_n = state == IDLE ? (any ? (zero ? DONE : WAIT) : IDLE)
            : state == WAIT ? (cnt == '0 ? DONE : WAIT) : IDLE;
  always_ff @(posedge ctl_clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // a request landing on its own grant cycle is a fresh request, not an overrun
  always_ff @(posedge ctl_clk)
    if (!reset) begin
      pending <= '0;
      overrun <= '0;
      ptr     <= '0;
      g       <= '0;
      cnt     <= '0;
      div_a   <= '0;
      div_b   <= '0;
      q_out   <= '0;
      r_out   <= '0;
    end else begin
      pending <= (pending & ~clr) | req;
      overrun <= overrun | (req & pending & ~clr);
      if (state == IDLE && any) begin
        g     <= idx;
        div_a <= a_sel;
        div_b <= b_sel;
        cnt   <= CW'(DIV_LATENCY - 1);
        ptr   <= idx == IW'(N_VOICES - 1) ? '0 : idx + 1'b1;
        if (zero) begin
          `SDD_SLICE(q_out, idx, C_WIDTH) <= '1;
          `SDD_SLICE(r_out, idx, C_WIDTH) <= a_sel;
        end
      end else if (state == WAIT) begin
        if (cnt == '0) begin
          `SDD_SLICE(q_out, g, C_WIDTH) <= div_q;
          `SDD_SLICE(r_out, g, C_WIDTH) <= div_r;
        end else cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_div_voice_scheduler.sv
// tb_div_voice_scheduler: directed checks of the divider scheduler with a real array_divider.
module tb_div_voice_scheduler;
  logic ctl_clk = 1'b0, reset = 1'b0, busy;
  logic [3:0] req = '0, done, overrun, exp_d;
  logic [31:0] voice_a = '0, voice_b = '0, q_out, r_out;
  logic [7:0] div_a, div_b, div_q, div_r;
  int n_chk = 0, n_fail = 0, nd;
  int vc [4];
  always #5 ctl_clk = ~ctl_clk;
  div_voice_scheduler dut (
    .ctl_clk(ctl_clk), .reset(reset), .req(req), .voice_a(voice_a), .voice_b(voice_b),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .q_out(q_out), .r_out(r_out), .done(done), .overrun(overrun), .busy(busy)
  );
  array_divider #(.C_WIDTH(8), .USE_CLA(1)) u_div (.a(div_a), .b(div_b), .q(div_q), .r(div_r));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge ctl_clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    tick(2);
    reset = 1'b1;
  endtask
  initial begin
    tick(2);
    chk("rst_q", q_out, 32'h0);
    chk("rst_r", r_out, 32'h0);
    chk("rst_done", done, 4'h0);
    chk("rst_ovr", overrun, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_diva", div_a, 8'h00);
    reset = 1'b1;
    voice_a[7:0] = 8'h0f; voice_b[7:0] = 8'h05; req = 4'b0001;
    tick; req = '0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_done_c1", done, 4'h0);
    tick;
    chk("t1_diva", div_a, 8'h0f);
    chk("t1_divb", div_b, 8'h05);
    tick(2);
    chk("t1_done_c4", done, 4'b0001);
    chk("t1_q", q_out[7:0], 8'h03);
    chk("t1_r", r_out[7:0], 8'h00);
    tick;
    chk("t1_done_c5", done, 4'h0);
    chk("t1_idle", busy, 1'b0);
    do_reset;
    voice_a = 32'hff001035; voice_b = 32'h10000305; req = 4'b1011;
    tick; req = '0;
    for (int c = 2; c <= 12; c++) begin
      tick;
      exp_d = c == 4 ? 4'b0001 : c == 8 ? 4'b0010 : c == 12 ? 4'b1000 : 4'b0000;
      chk("t2_done", done, exp_d);
    end
    chk("t2_q", q_out, 32'h0f00050a);
    chk("t2_r", r_out, 32'h0f000103);
    do_reset;
    voice_a = 32'h47362514; voice_b = 32'h04030201; req = 4'hf; nd = 0;
    for (int i = 0; i < 4; i++) vc[i] = 0;
    for (int k = 0; k < 64; k++) begin
      tick;
      req = done;
      if (done != 4'h0) begin
        exp_d = 4'b0001 << (nd % 4);
        chk("t3_order", done, exp_d);
        for (int i = 0; i < 4; i++) if (done[i]) vc[i]++;
        nd++;
      end
    end
    req = '0;
    chk("t3_ovr", overrun, 4'h0);
    for (int i = 0; i < 4; i++) chk("t3_count", vc[i] >= 3, 1'b1);
    do_reset;
    voice_a = 32'h00200007; voice_b = 32'h00040002; req = 4'b0101;
    tick; req = '0;
    tick; req = 4'b0100;
    tick; req = '0;
    chk("t4_ovr", overrun, 4'b0100);
    nd = 0;
    for (int k = 0; k < 9; k++) begin tick; if (done[2]) nd++; end
    chk("t4_one_done", nd, 1);
    chk("t4_q2", q_out[23:16], 8'h08);
    chk("t4_q0", q_out[7:0], 8'h03);
    chk("t4_r0", r_out[7:0], 8'h01);
    req = 4'b0100;
    tick; req = 4'b0100;
    tick; req = '0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin tick; if (done[2]) nd++; end
    chk("t4_two_done", nd, 2);
    chk("t4_ovr_sticky", overrun, 4'b0100);
    do_reset;
    voice_a = 32'h00000055; voice_b = 32'h00000005; req = 4'b0001;
    tick; req = '0;
    tick; reset = 1'b0;
    tick;
    chk("t5_done", done, 4'h0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_diva", div_a, 8'h00);
    chk("t5_q", q_out, 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin tick; chk("t5_no_done", done, 4'h0); end
    voice_a[7:0] = 8'h64; voice_b[7:0] = 8'h07; req = 4'b0001;
    tick; req = '0;
    tick(3);
    chk("t5_done_new", done, 4'b0001);
    chk("t5_q_new", q_out[7:0], 8'h0e);
    chk("t5_r_new", r_out[7:0], 8'h02);
    voice_a[15:8] = 8'h2a; voice_b[15:8] = 8'h00; req = 4'b0010;
    tick; req = '0;
    tick;
`ifdef DIV_ZERO_DETECT_EN
    chk("t6_done_c2", done, 4'b0010);
`else
    chk("t6_done_c2", done, 4'b0000);
`endif
    tick;
    chk("t6_done_c3", done, 4'b0000);
    tick;
`ifdef DIV_ZERO_DETECT_EN
    chk("t6_done_c4", done, 4'b0000);
`else
    chk("t6_done_c4", done, 4'b0010);
`endif
    chk("t6_q", q_out[15:8], 8'hff);
    chk("t6_r", r_out[15:8], 8'h2a);
    chk("t6_slot0", q_out[7:0], 8'h0e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
